// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, word geometry.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE_RD,
        ST_STORE_WR,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select with sign/zero extension (little-endian lanes).
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{byte_off, 3'b000} +: 8];
        lane_h = byte_off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SIZE_HALF: data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only data memory; sub-word stores use read-modify-write.
//
// state       | meaning
// ST_IDLE     | ready for a request, memory idle, mem_address = 0
// ST_LOAD     | memory read, extended lane captured into resp_rdata
// ST_STORE_RD | memory read of the word about to be partially overwritten
// ST_STORE_WR | single memory write (full word or merged word)
// ST_RESP     | resp_valid pulse, then back to idle
module load_store_unit
    import mem_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state, state_next;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_wdata;
    logic [31:0] merge_buf;

    logic        accept;
    logic [1:0]  size_n;
    logic        misaligned;
    logic        err_req;
    logic [1:0]  addr_lo_n;
    logic [31:0] ext_data;
    logic [31:0] merged;

    assign accept = req_valid && (state == ST_IDLE);

    // Reserved size 11 is folded into word at capture so later logic sees only three sizes.
    always_comb begin
        size_n     = (req_size == 2'b11) ? SIZE_WORD : req_size;
        misaligned = ((size_n == SIZE_HALF) && req_addr[0]) ||
                     ((size_n == SIZE_WORD) && (req_addr[1:0] != 2'b00));
        err_req    = ALIGN_CHECK && misaligned;
        case (size_n)
            SIZE_WORD: addr_lo_n = 2'b00;
            SIZE_HALF: addr_lo_n = {req_addr[1], 1'b0};
            default:   addr_lo_n = req_addr[1:0];
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (err_req)
                        state_next = ST_RESP;
                    else if (!req_write)
                        state_next = ST_LOAD;
                    else if (size_n == SIZE_WORD)
                        state_next = ST_STORE_WR;
                    else
                        state_next = ST_STORE_RD;
                end
            end
            ST_LOAD:     state_next = ST_RESP;
            ST_STORE_RD: state_next = ST_STORE_WR;
            ST_STORE_WR: state_next = ST_RESP;
            ST_RESP:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign mem_read   = (state == ST_LOAD) || (state == ST_STORE_RD);
    assign mem_write  = (state == ST_STORE_WR);

    always_comb begin
        merged = merge_buf;
        case (r_size)
            SIZE_BYTE: merged[{r_addr_lo, 3'b000} +: 8]     = r_wdata[7:0];
            SIZE_HALF: merged[{r_addr_lo[1], 4'b0000} +: 16] = r_wdata[15:0];
            default:   merged = r_wdata;
        endcase
        mem_write_data = (state == ST_STORE_WR) ? merged : 32'h0;
    end

    load_extend u_load_extend (
        .word        (mem_read_data),
        .byte_off    (r_addr_lo),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .data        (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            r_write     <= 1'b0;
            r_size      <= SIZE_BYTE;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_wdata     <= 32'h0;
            merge_buf   <= 32'h0;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
            mem_address <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        r_write     <= req_write;
                        r_size      <= size_n;
                        r_unsigned  <= req_unsigned;
                        r_addr_lo   <= addr_lo_n;
                        r_wdata     <= req_wdata;
                        resp_rdata  <= 32'h0;
                        resp_err    <= err_req;
                        mem_address <= {req_addr[31:2], 2'b00};
                    end
                end
                ST_LOAD:     resp_rdata <= ext_data;
                ST_STORE_RD: merge_buf  <= mem_read_data;
                ST_RESP: begin
                    resp_rdata  <= 32'h0;
                    resp_err    <= 1'b0;
                    mem_address <= 32'h0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory behind each instance.
module tb_load_store_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

    logic        req_valid2 = 1'b0;
    logic [31:0] req_addr2 = 32'h0;
    logic        req_ready2, resp_valid2, resp_err2, mem_read2, mem_write2;
    logic [31:0] resp_rdata2, mem_address2, mem_write_data2, mem_read_data2;

    logic [31:0] mem  [0:255];
    logic [31:0] mem2 [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    load_store_unit #(.ALIGN_CHECK(1'b0)) u_dut_noalign (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(1'b0),
        .req_size(SIZE_WORD), .req_unsigned(1'b0), .req_addr(req_addr2),
        .req_wdata(32'h0), .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
        .resp_err(resp_err2), .mem_read(mem_read2), .mem_write(mem_write2),
        .mem_address(mem_address2), .mem_write_data(mem_write_data2),
        .mem_read_data(mem_read_data2)
    );

    assign mem_read_data  = mem[mem_address[9:2]];
    assign mem_read_data2 = mem2[mem_address2[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= 32'h0;
                mem2[i] <= 32'h0;
            end
            mem[8'h40]  <= 32'h8899AABB;
            mem2[8'h40] <= 32'h8899AABB;
        end else begin
            if (mem_write)  mem[mem_address[9:2]]   <= mem_write_data;
            if (mem_write2) mem2[mem_address2[9:2]] <= mem_write_data2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after the response.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input logic [31:0] exp_wd);
        int          lat = 0, nrd = 0, nwr = 0;
        int          exp_nrd, exp_nwr;
        logic [31:0] obs_rd = 32'h0, obs_wd = 32'h0;
        logic        obs_err = 1'b0, addr_bad = 1'b0, ready_bad = 1'b0;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        exp_nrd  = (exp_err || (wr && sz[1])) ? 0 : 1;
        exp_nwr  = (!exp_err && wr) ? 1 : 0;
        check({tag, " ready"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; obs_wd = mem_write_data; end
            if (mem_address !== exp_addr) addr_bad = 1'b1;
            if (req_ready) ready_bad = 1'b1;
            if (resp_valid) begin
                lat = k; obs_rd = resp_rdata; obs_err = resp_err;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, obs_rd, exp_rd);
        check({tag, " err"}, {31'h0, obs_err}, {31'h0, exp_err});
        check({tag, " reads"}, nrd, exp_nrd);
        check({tag, " writes"}, nwr, exp_nwr);
        if (exp_nwr == 1) check({tag, " wdata"}, obs_wd, exp_wd);
        check({tag, " addr held"}, {31'h0, addr_bad}, 32'd0);
        check({tag, " busy"}, {31'h0, ready_bad}, 32'd0);
        @(negedge clk);
        check({tag, " idle addr"}, mem_address, 32'h0);
    endtask

    initial begin
        logic        b_wr  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] b_adr [3] = '{32'h100, 32'h108, 32'h108};
        logic [31:0] b_wd  [3] = '{32'h0, 32'h11223344, 32'h0};
        logic [31:0] b_exp [3] = '{32'h1234AA77, 32'h0, 32'h11223344};
        logic [31:0] got   [3];
        int          idx, nresp, extra, cyc, nwr_rst, lat2;
        logic        rb;
        logic [31:0] rd2, ad2;
        logic        er2;

        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;

        check("reset ready", {31'h0, req_ready}, 32'd1);
        check("reset resp_valid", {31'h0, resp_valid}, 32'd0);
        check("reset rdata", resp_rdata, 32'h0);
        check("reset mem_rw", {30'h0, mem_read, mem_write}, 32'd0);
        check("reset mem_address", mem_address, 32'h0);
        check("reset wdata", mem_write_data, 32'h0);

        do_req("lb 101",  1'b0, SIZE_BYTE, 1'b0, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 32'h0);
        do_req("lbu 101", 1'b0, SIZE_BYTE, 1'b1, 32'h101, 32'h0, 32'h000000AA, 1'b0, 2, 32'h0);
        do_req("lh 102",  1'b0, SIZE_HALF, 1'b0, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2, 32'h0);
        do_req("lw 100",  1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2, 32'h0);
        do_req("sh 102",  1'b1, SIZE_HALF, 1'b0, 32'h102, 32'hDEAD1234, 32'h0, 1'b0, 3, 32'h1234AABB);
        check("sh 102 mem", mem[8'h40], 32'h1234AABB);
        do_req("sb 100",  1'b1, SIZE_BYTE, 1'b0, 32'h100, 32'h00000077, 32'h0, 1'b0, 3, 32'h1234AA77);
        check("sb 100 mem", mem[8'h40], 32'h1234AA77);
        do_req("sw 104",  1'b1, SIZE_WORD, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 1'b0, 2, 32'hCAFEF00D);
        check("sw 104 mem", mem[8'h41], 32'hCAFEF00D);
        do_req("lw 104",  1'b0, SIZE_WORD, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0, 2, 32'h0);
        do_req("l11 104", 1'b0, 2'b11,     1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0, 2, 32'h0);
        do_req("lh 100",  1'b0, SIZE_HALF, 1'b0, 32'h100, 32'h0, 32'hFFFFAA77, 1'b0, 2, 32'h0);
        do_req("lhu 102", 1'b0, SIZE_HALF, 1'b1, 32'h102, 32'h0, 32'h00001234, 1'b0, 2, 32'h0);
        do_req("lb 103",  1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h00000012, 1'b0, 2, 32'h0);
        do_req("lw 102 err", 1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 32'h0);
        do_req("sh 101 err", 1'b1, SIZE_HALF, 1'b0, 32'h101, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 32'h0);
        do_req("s11 105 err", 1'b1, 2'b11, 1'b0, 32'h105, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 32'h0);
        check("err mem 100", mem[8'h40], 32'h1234AA77);
        check("err mem 104", mem[8'h41], 32'hCAFEF00D);

        // Back-to-back with req_valid held high across busy cycles.
        idx = 0; nresp = 0; rb = 1'b0;
        for (cyc = 0; cyc < 40 && !(nresp == 3 && idx == 3); cyc++) begin
            if (resp_valid) begin
                if (nresp < 3) got[nresp] = resp_rdata;
                nresp++;
            end
            if (req_ready && (mem_read || mem_write || resp_valid)) rb = 1'b1;
            if (req_ready && idx < 3) begin
                req_valid = 1'b1; req_write = b_wr[idx]; req_size = SIZE_WORD;
                req_unsigned = 1'b0; req_addr = b_adr[idx]; req_wdata = b_wd[idx];
                idx++;
            end
            if (!(nresp == 3 && idx == 3)) @(negedge clk);
        end
        req_valid = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        check("b2b responses", nresp, 3);
        check("b2b extra", extra, 0);
        check("b2b ready overlap", {31'h0, rb}, 32'd0);
        for (int i = 0; i < 3; i++) check($sformatf("b2b rdata%0d", i), got[i], b_exp[i]);
        check("b2b mem 108", mem[8'h42], 32'h11223344);

        // Asynchronous reset in the middle of a read-modify-write.
        req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_BYTE; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst in STORE_RD", {31'h0, mem_read}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst ready", {31'h0, req_ready}, 32'd1);
        check("rst mem_rw", {30'h0, mem_read, mem_write}, 32'd0);
        check("rst resp", {31'h0, resp_valid}, 32'd0);
        check("rst mem_address", mem_address, 32'h0);
        check("rst wdata", mem_write_data, 32'h0);
        nwr_rst = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_write) nwr_rst++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_write) nwr_rst++;
        end
        check("rst no write", nwr_rst, 0);
        check("rst mem 100", mem[8'h40], 32'h1234AA77);
        do_req("lbu 100 post", 1'b0, SIZE_BYTE, 1'b1, 32'h100, 32'h0, 32'h00000077, 1'b0, 2, 32'h0);

        // ALIGN_CHECK=0: misaligned word load reads the containing word.
        req_valid2 = 1'b1; req_addr2 = 32'h102;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        lat2 = 0; rd2 = 32'h0; er2 = 1'b0; ad2 = 32'h0;
        for (int k = 1; k <= 8 && lat2 == 0; k++) begin
            @(negedge clk);
            if (k == 1) ad2 = mem_address2;
            if (resp_valid2) begin lat2 = k; rd2 = resp_rdata2; er2 = resp_err2; end
        end
        check("noalign latency", lat2, 2);
        check("noalign rdata", rd2, 32'h8899AABB);
        check("noalign err", {31'h0, er2}, 32'd0);
        check("noalign addr", ad2, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
